timer_req_scheduler: RTL and testbench

Sequencer and arbiter that shares one countdown timer between several delay requesters: arm, driver-door, passenger-door and alarm-duration delays. It grants one requester at a time and loads that requester's delay value. It counts down on an internal prescaled tick and returns a one-cycle expire pulse to the granted requester. It sits between the anti-theft FSM request lines and the timing resource.

---
 rtl/car_alarm_pkg.sv | 27 ++
 rtl/timer_req_scheduler_if.sv | 32 +++
 rtl/timer_req_scheduler_tick.sv | 35 +++
 rtl/timer_req_scheduler.sv | 151 +++++++++++++++
 tb/tb_timer_req_scheduler.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/car_alarm_pkg.sv
// ---------------------------------------------------------------------------
// car_alarm_pkg
// Shared definitions for the car-alarm timing slice.
//   - state_t          : scheduler FSM encoding
//   - REQ_*            : requester index assignment (0 = highest priority)
//   - DELAY_*          : default delay values, in prescaled ticks
// ---------------------------------------------------------------------------
package car_alarm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int REQ_ARM   = 0;
    localparam int REQ_DRV   = 1;
    localparam int REQ_PASS  = 2;
    localparam int REQ_ALARM = 3;

    localparam int DELAY_ARM   = 10;
    localparam int DELAY_DRV   = 8;
    localparam int DELAY_PASS  = 15;
    localparam int DELAY_ALARM = 3;

endpackage

// File: rtl/timer_req_scheduler_if.sv
// ---------------------------------------------------------------------------
// timer_req_scheduler_if
// Request/grant bundle between the delay requesters and the shared timer.
//   req       : level request per requester
//   delay_val : packed per-requester delay, slice i = [i*TW +: TW]
//   grant     : one-hot current timer owner
//   busy      : scheduler is loading, running or completing
//   expire    : one-cycle completion pulse on the owner's bit
//   remain    : current countdown value
// Modports: master = requester side, slave = scheduler side.
// ---------------------------------------------------------------------------
interface timer_req_scheduler_if #(
    parameter int NREQ = 4,
    parameter int TW   = 4
);
    logic [NREQ-1:0]    req;
    logic [NREQ*TW-1:0] delay_val;
    logic [NREQ-1:0]    grant;
    logic               busy;
    logic [NREQ-1:0]    expire;
    logic [TW-1:0]      remain;

    modport master (
        output req, delay_val,
        input  grant, busy, expire, remain
    );

    modport slave (
        input  req, delay_val,
        output grant, busy, expire, remain
    );
endinterface

// File: rtl/timer_req_scheduler_tick.sv
// ---------------------------------------------------------------------------
// tick_prescaler
// Modulo-TICK_DIV counter that produces the countdown tick.
//   clk, reset : clock and asynchronous active-high reset
//   clr        : synchronous clear back to 0 (wins over en)
//   en         : count enable
//   tick       : high while enabled and the count sits at TICK_DIV-1
// ---------------------------------------------------------------------------
module tick_prescaler #(
    parameter int TICK_DIV = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int             CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0]  LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= (count_reg == LAST) ? '0 : count_reg + CW'(1);
        end
    end

    assign tick = en && (count_reg == LAST);

endmodule

// File: rtl/timer_req_scheduler.sv
// ---------------------------------------------------------------------------
// timer_req_scheduler
// Shares one countdown timer between NREQ delay requesters. The lowest-index
// eligible request is granted, its delay is loaded, the count runs on a
// prescaled tick and a one-cycle expire pulse returns to the owner.
//   clk, reset : clock and asynchronous active-high reset
//   bus        : timer_req_scheduler_if.slave (req, delay_val in;
//                grant, busy, expire, remain out)
// Optional build macro TIMER_PREEMPT_EN: a lower-index eligible request
// takes the timer away from the current owner during RUN.
// ---------------------------------------------------------------------------
module timer_req_scheduler #(
    parameter int NREQ     = 4,
    parameter int TW       = 4,
    parameter int TICK_DIV = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    timer_req_scheduler_if.slave   bus
);
    import car_alarm_pkg::*;

    state_t          state_reg, state_next;
    logic [NREQ-1:0] grant_reg, grant_next;
    logic [NREQ-1:0] served_reg, served_next;
    logic [TW-1:0]   remain_reg, remain_next;

    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] pick;
    logic            owner_present;
    logic            preempt;
    logic            tick;
    logic [TW-1:0]   slice_masked [NREQ];
    logic [TW-1:0]   granted_delay;

    // A requester that already expired stays ineligible until it drops req.
    assign eligible      = bus.req & ~served_reg;
    // Isolate the lowest set bit: lowest index has priority.
    assign pick          = eligible & (~eligible + NREQ'(1));
    assign owner_present = |(bus.req & grant_reg);

    // One-hot grant selects its delay slice by masking and OR-reducing.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
            assign slice_masked[gi] = grant_reg[gi] ? bus.delay_val[gi*TW +: TW] : '0;
        end
    endgenerate

    always_comb begin
        granted_delay = '0;
        for (int i = 0; i < NREQ; i++) begin
            granted_delay = granted_delay | slice_masked[i];
        end
    end

`ifdef TIMER_PREEMPT_EN
    // Both vectors are one-hot, so a smaller value means a lower index.
    assign preempt = (pick != '0) && (pick < grant_reg);
`else
    assign preempt = 1'b0;
`endif

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (state_reg != RUN),
        .en    (state_reg == RUN),
        .tick  (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            grant_reg  <= '0;
            served_reg <= '0;
            remain_reg <= '0;
        end else begin
            state_reg  <= state_next;
            grant_reg  <= grant_next;
            served_reg <= served_next;
            remain_reg <= remain_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        grant_next  = grant_reg;
        remain_next = remain_reg;
        served_next = served_reg & bus.req;

        case (state_reg)
            IDLE: begin
                remain_next = '0;
                if (|eligible) begin
                    grant_next = pick;
                    state_next = LOAD;
                end
            end

            LOAD: begin
                if (!owner_present) begin
                    grant_next  = '0;
                    remain_next = '0;
                    state_next  = IDLE;
                end else begin
                    remain_next = granted_delay;
                    state_next  = (granted_delay == '0) ? DONE : RUN;
                end
            end

            RUN: begin
                if (!owner_present) begin
                    grant_next  = '0;
                    remain_next = '0;
                    state_next  = IDLE;
                end else if (preempt) begin
                    // Displaced owner is not marked served, so it is
                    // re-granted later with its full delay.
                    grant_next = pick;
                    state_next = LOAD;
                end else if (tick && (remain_reg != '0)) begin
                    remain_next = remain_reg - TW'(1);
                    if (remain_reg == TW'(1)) begin
                        state_next = DONE;
                    end
                end
            end

            DONE: begin
                served_next = served_next | grant_reg;
                grant_next  = '0;
                remain_next = '0;
                state_next  = IDLE;
            end

            default: begin
                grant_next  = '0;
                remain_next = '0;
                state_next  = IDLE;
            end
        endcase
    end

    assign bus.grant  = grant_reg;
    assign bus.busy   = (state_reg != IDLE);
    assign bus.expire = (state_reg == DONE) ? grant_reg : '0;
    assign bus.remain = remain_reg;

endmodule

// File: tb/tb_timer_req_scheduler.sv
// ---------------------------------------------------------------------------
// tb_timer_req_scheduler
// Scoreboard bench: each stimulus pushes its expected expire (requester and
// cycle) into a queue; a negedge monitor pops and compares on every expire.
// ---------------------------------------------------------------------------
module tb_timer_req_scheduler;
    localparam int NREQ = 4;
    localparam int TW   = 4;
    localparam int TD   = 4;

    typedef struct {
        int idx;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    int   c;

    timer_req_scheduler_if #(.NREQ(NREQ), .TW(TW)) bus_if ();

    timer_req_scheduler #(
        .NREQ     (NREQ),
        .TW       (TW),
        .TICK_DIV (TD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_delay(input int idx, input int val);
        bus_if.delay_val[idx*TW +: TW] = TW'(val);
    endtask

    task automatic expect_expire(input int idx, input int at_cyc);
        exp_t e;
        e.idx = idx;
        e.cyc = at_cyc;
        exp_q.push_back(e);
        $display("[TB] queued expire req %0d at cycle %0d", idx, at_cyc);
    endtask

    task automatic drain(input int max_cycles);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < max_cycles) begin
            next_cycle();
            k++;
        end
        if (exp_q.size() != 0) begin
            check_eq("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    // Expire monitor: every pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && bus_if.expire != '0) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_expire", int'(bus_if.expire), 0);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("expire_vec", int'(bus_if.expire), 1 << mon_e.idx);
                check_eq("expire_cyc", cyc, mon_e.cyc);
                $display("[TB] expire 0x%0h at cycle %0d (expected req %0d at %0d)",
                         bus_if.expire, cyc, mon_e.idx, mon_e.cyc);
            end
        end
    end

    initial begin
        bus_if.req       = '0;
        bus_if.delay_val = '0;
        reset            = 1'b1;
        repeat (3) next_cycle();
        check_eq("rst_grant",  int'(bus_if.grant),  0);
        check_eq("rst_busy",   int'(bus_if.busy),   0);
        check_eq("rst_expire", int'(bus_if.expire), 0);
        check_eq("rst_remain", int'(bus_if.remain), 0);
        reset = 1'b0;
        next_cycle();

        // Single request, delay 8; late delay change must be ignored.
        set_delay(1, 8);
        bus_if.req[1] = 1'b1;
        c = cyc;
        expect_expire(1, c + 2 + 8 * TD);
        next_cycle();
        check_eq("s1_grant", int'(bus_if.grant), 4'b0010);
        check_eq("s1_busy",  int'(bus_if.busy),  1);
        next_cycle();
        check_eq("s1_remain", int'(bus_if.remain), 8);
        set_delay(1, 3);
        drain(200);
        check_eq("s1_busy_after",  int'(bus_if.busy),  0);
        check_eq("s1_grant_after", int'(bus_if.grant), 0);
        next_cycle();
        check_eq("s1_served_hold", int'(bus_if.grant), 0);
        bus_if.req = '0;
        next_cycle();

        // Simultaneous req[0] and req[2]: 0 first, then 2; 0 needs a toggle.
        set_delay(0, 2);
        set_delay(2, 3);
        bus_if.req = 4'b0101;
        c = cyc;
        expect_expire(0, c + 2 + 2 * TD);
        expect_expire(2, c + 2 + 2 * TD + 1 + 2 + 3 * TD);
        next_cycle();
        check_eq("s2_grant0", int'(bus_if.grant), 4'b0001);
        drain(200);
        next_cycle();
        next_cycle();
        check_eq("s2_no_regrant", int'(bus_if.grant), 0);
        bus_if.req[0] = 1'b0;
        next_cycle();
        bus_if.req[0] = 1'b1;
        c = cyc;
        expect_expire(0, c + 2 + 2 * TD);
        next_cycle();
        check_eq("s2_regrant0", int'(bus_if.grant), 4'b0001);
        drain(200);
        bus_if.req = '0;
        next_cycle();

        // Zero delay on req[3].
        set_delay(3, 0);
        bus_if.req = 4'b1000;
        c = cyc;
        expect_expire(3, c + 2);
        next_cycle();
        check_eq("s3_grant", int'(bus_if.grant), 4'b1000);
        next_cycle();
        check_eq("s3_remain", int'(bus_if.remain), 0);
        drain(50);
        bus_if.req = '0;
        next_cycle();

        // Abort: drop req[2] mid-RUN at remain 5.
        set_delay(2, 9);
        bus_if.req = 4'b0100;
        c = cyc;
        repeat (19) next_cycle();
        check_eq("s4_remain5", int'(bus_if.remain), 5);
        bus_if.req = '0;
        next_cycle();
        check_eq("s4_grant", int'(bus_if.grant),  0);
        check_eq("s4_remain", int'(bus_if.remain), 0);
        check_eq("s4_busy",  int'(bus_if.busy),   0);
        repeat (40) next_cycle();

        // Asynchronous reset mid-RUN at remain 3, then re-grant.
        set_delay(3, 5);
        bus_if.req = 4'b1000;
        c = cyc;
        expect_expire(3, c + 2 + 5 * TD);
        repeat (11) next_cycle();
        check_eq("s5_remain3", int'(bus_if.remain), 3);
        reset = 1'b1;
        exp_q.delete();
        #1;
        check_eq("s5_rst_grant",  int'(bus_if.grant),  0);
        check_eq("s5_rst_busy",   int'(bus_if.busy),   0);
        check_eq("s5_rst_remain", int'(bus_if.remain), 0);
        check_eq("s5_rst_expire", int'(bus_if.expire), 0);
        next_cycle();
        next_cycle();
        reset = 1'b0;
        c = cyc;
        expect_expire(3, c + 2 + 5 * TD);
        next_cycle();
        check_eq("s5_regrant", int'(bus_if.grant), 4'b1000);
        drain(200);
        bus_if.req = '0;
        next_cycle();

        // Lower-index request arriving while req[2] runs.
        set_delay(2, 4);
        bus_if.req = 4'b0100;
        c = cyc;
        repeat (5) next_cycle();
        set_delay(0, 2);
        bus_if.req[0] = 1'b1;
`ifdef TIMER_PREEMPT_EN
        expect_expire(0, c + 15);
        expect_expire(2, c + 34);
        next_cycle();
        check_eq("s6_grant", int'(bus_if.grant), 4'b0001);
`else
        expect_expire(2, c + 18);
        expect_expire(0, c + 29);
        next_cycle();
        check_eq("s6_grant", int'(bus_if.grant), 4'b0100);
`endif
        drain(300);
        bus_if.req = '0;
        repeat (5) next_cycle();
        check_eq("final_queue", exp_q.size(), 0);
        check_eq("final_busy", int'(bus_if.busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
